// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-clock frame, ACK check, timeout)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2400,
    parameter int TIMEOUT_CYCLES = 48000
) (
    input  logic       clk_i,
    input  logic       res_n_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);
    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT} state_t;
    state_t r_state, w_next;
    logic r_clk_s1, r_clk_s2, r_clk_d, r_dat_s1, r_dat_s2;
    logic [CW-1:0] r_cnt;
    logic [3:0] r_bitn;
    logic [9:0] r_shift;
    logic r_dat_oe;
    logic w_fe, w_active, w_timeout, w_inh_done, w_send_fe;
    assign w_fe       = r_clk_d & ~r_clk_s2;
    assign w_active   = r_state inside {S_REQ, S_SEND, S_ACK, S_WAIT};
    assign w_timeout  = w_active && r_cnt == CW'(TIMEOUT_CYCLES);
    assign w_inh_done = r_state == S_INHIBIT && r_cnt == CW'(INHIBIT_CYCLES - 1);
    assign w_send_fe  = r_state == S_SEND && w_fe;
    always_ff @(posedge clk_i) begin
        if (!res_n_i) r_state <= S_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (w_timeout) w_next = S_IDLE;
        else
            case (r_state)
                S_IDLE:    w_next = tx_valid_i ? S_INHIBIT : S_IDLE;
                S_INHIBIT: w_next = w_inh_done ? S_REQ : S_INHIBIT;
                S_REQ:     w_next = S_SEND;
                S_SEND:    w_next = (w_fe && r_bitn == 4'd9) ? S_ACK : S_SEND;
                S_ACK:     w_next = w_fe ? (r_dat_s2 ? S_IDLE : S_WAIT) : S_ACK;
                S_WAIT:    w_next = (r_clk_s2 && r_dat_s2) ? S_IDLE : S_WAIT;
                default:   w_next = S_IDLE;
            endcase
    end
    always_comb begin
        tx_ready_o   = r_state == S_IDLE;
        busy_o       = r_state != S_IDLE;
        ps2_clk_oe_o = (r_state == S_INHIBIT || r_state == S_REQ) && !w_timeout;
        ps2_dat_oe_o = (r_state == S_REQ || (r_state == S_SEND && r_dat_oe)) && !w_timeout;
        err_o        = res_n_i && (w_timeout || (r_state == S_ACK && w_fe && r_dat_s2));
        done_o       = res_n_i && !w_timeout && r_state == S_WAIT && r_clk_s2 && r_dat_s2;
    end
    // frame shifts out LSB first; the stop slot is 1 so the line is released after parity
    always_ff @(posedge clk_i) begin
        if (!res_n_i) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_cnt    <= '0;
            r_bitn   <= '0;
            r_shift  <= '0;
            r_dat_oe <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_dat_i;
            r_dat_s2 <= r_dat_s1;
            r_shift  <= (r_state == S_IDLE && tx_valid_i) ? {1'b1, ~^tx_data_i, tx_data_i} :
                        w_send_fe ? {1'b1, r_shift[9:1]} : r_shift;
            r_dat_oe <= (r_state == S_REQ) ? 1'b1 : w_send_fe ? ~r_shift[0] : r_dat_oe;
            r_bitn   <= (r_state == S_REQ) ? 4'd0 : w_send_fe ? r_bitn + 4'd1 : r_bitn;
            r_cnt    <= (r_state == S_IDLE || w_inh_done || w_timeout || (w_active && w_fe)) ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2400, the number of clk_i cycles the host holds PS/2 clock low before a request (at least 100 us).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 48000, the maximum number of clk_i cycles allowed between device clock falling edges, and after the last edge, before the transfer aborts.
REQ-003 clk_i  in  1  system clock; the only clock.
REQ-004 res_n_i  in  1  reset; synchronous, active-low.
REQ-005 tx_data_i  in  8  command/data byte to send to the device.
REQ-006 tx_valid_i  in  1  request to send tx_data_i.
REQ-007 tx_ready_o  out  1  high only in IDLE; a transfer is accepted when tx_valid_i and tx_ready_o are both high.
REQ-008 ps2_clk_i, ps2_dat_i  in  1 each  raw, asynchronous line levels.
REQ-009 ps2_clk_oe_o, ps2_dat_oe_o  out  1 each  1 = pull line low, 0 = release (open-drain; the top level ties the line to 0 or Z).
REQ-010 busy_o  out  1  high in every state except IDLE; the paired scancode receiver ignores the lines while busy_o is high.
REQ-011 done_o  out  1  one-cycle pulse when the device acknowledges the byte.
REQ-012 err_o  out  1  one-cycle pulse on NACK or timeout.

Function
REQ-013 SHALL pass ps2_clk_i and ps2_dat_i each through a 2-flop synchronizer; a device falling edge (fe) is a synced-clock transition from 1 to 0, one cycle wide.
REQ-014 SHALL latch tx_data_i and compute odd parity (parity = ~^data) in the accept cycle, then move IDLE -> INHIBIT.
REQ-015 INHIBIT: clk_oe=1, dat_oe=0; count INHIBIT_CYCLES, then go to REQ.
REQ-016 REQ: dat_oe=1 (start bit 0) for 1 cycle with clk_oe=1; next cycle clk_oe=0; then go to SEND with bit index 0.
REQ-017 SEND: on each fe, dat_oe is updated in the cycle after fe, in this order:
  - fe 1..8: data bits 0..7, LSB first, with dat_oe = ~bit.
  - fe 9: dat_oe = ~parity.
  - fe 10: dat_oe=0 (stop bit, line released).
REQ-018 ACK: on fe 11, sample synced data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: pulse err_o and go to IDLE.
REQ-019 WAIT_IDLE: when synced clock and data are both 1, pulse done_o and go to IDLE.
REQ-020 SHALL reset the timeout counter on entry to REQ and on every fe.
REQ-021 In REQ, SEND, ACK or WAIT_IDLE, when the counter reaches TIMEOUT_CYCLES: release both lines, pulse err_o, go to IDLE.
REQ-022 tx_valid_i while busy_o=1 SHALL be ignored and not queued.
REQ-023 tx_data_i changes after acceptance SHALL NOT affect the byte in flight.
REQ-024 done_o and err_o SHALL never be asserted in the same cycle.
REQ-025 Every return to IDLE SHALL leave clk_oe=dat_oe=0 in the same cycle as tx_ready_o=1.
REQ-026 fe events in IDLE or INHIBIT SHALL be ignored.

Reset
REQ-027 res_n_i=0 at a clock edge SHALL force:
  - state IDLE, all counters 0, synchronizers to 1;
  - clk_oe=0, dat_oe=0, busy=0, done=0, err=0, tx_ready=1 from the next cycle.
REQ-028 Reset mid-transfer SHALL release both lines immediately, without an err_o pulse.

Verification
REQ-029 Send 0xED with a device model that clocks at 12.5 kHz and ACKs:
  - clk_oe low for 2400 cycles;
  - device samples data 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1;
  - done_o pulses once, err_o stays 0.
REQ-030 Send 0x00 -> parity bit sampled as 1; send 0x01 -> parity bit 0.
REQ-031 Device holds data high on the ACK clock -> err_o pulses once, no done_o, tx_ready_o=1 next cycle.
REQ-032 Device never clocks -> err_o pulses 2401+48000 (+/-2) cycles after acceptance; both oe outputs are 0.
REQ-033 Assert res_n_i=0 after fe 4:
  - oe outputs are 0 next cycle, no err_o;
  - a new 0xF4 transfer then completes with done_o.
REQ-034 Pulse tx_valid_i with 0x55 during an active 0xED transfer -> only 0xED appears on the line; 0x55 is dropped.
